mac_unit_pipe: RTL and testbench
================================

// Module: mac_unit_pipe
// PURPOSE
//  Parametrised, pipelined multiply-accumulate unit; successor to the fixed 8-bit MAC.
//  Adds a valid handshake, signed/unsigned mode, a wide accumulator with optional saturation,
//  and frame counting with auto-restart.
//  Used as the dot-product / FIR tap engine behind the data-path sequencers.
// PARAMETERS
//  DATA_W    8   width of operands A, B
//  ACC_W     20  accumulator width, must be >= 2*DATA_W
//  SIGNED    0   1: A, B, P, S are two's complement; 0: unsigned
//  SATURATE  1   1: clamp S at range limits; 0: wrap modulo 2^ACC_W
//  FRAME_LEN 4   samples per frame before done and auto-restart; 0 = free-running, no done
//  CNT_W     8   width of the count output
// PORTS
//  clock      in   1         single clock, rising edge
//  reset_p    in   1         asynchronous, active-high reset
//  in_valid   in   1         A, B, acc_clear are sampled when high
//  acc_clear  in   1         tagged sample starts a new accumulation (S <= product)
//  A          in   DATA_W    operand
//  B          in   DATA_W    operand
//  P          out  2*DATA_W  registered product of the last valid sample
//  S          out  ACC_W     accumulator
//  out_valid  out  1         S was updated on the previous edge
//  done       out  1         one-cycle pulse: S holds a completed frame
//  overflow   out  1         sticky saturation/wrap flag for the current accumulation
//  count      out  CNT_W     samples accumulated in the current frame
// BEHAVIOUR
//  Reset (async): P, S, count, out_valid, done, overflow, and all pipeline valids = 0.
//  Stage 1 (edge N, in_valid = 1):
//   - P <= A*B (signed or unsigned per SIGNED).
//   - v1 <= 1, clr1 <= acc_clear.
//   - in_valid = 0: P holds its value, v1 <= 0.
//  Stage 2 (edge N+1, v1 = 1):
//   - Start condition: clr1, or the previous sample completed a frame.
//   - Start: S <= ext(P), overflow <= 0, count <= 1.
//   - Otherwise: S <= S + ext(P), count <= count + 1.
//   - ext() sign-extends or zero-extends P to ACC_W per SIGNED.
//   - Latency: A/B to S = 2 edges; out_valid = 1 in the cycle after the S update.
//  Arithmetic:
//   - The sum is computed at ACC_W+1 bits.
//   - SATURATE = 1: clamp to [0, 2^ACC_W-1] (unsigned) or [-2^(ACC_W-1), 2^(ACC_W-1)-1] (signed).
//   - SATURATE = 0: keep the low ACC_W bits.
//   - Either mode sets overflow (sticky) when the true sum is out of range.
//  Frame: when FRAME_LEN > 0 and the update makes count == FRAME_LEN:
//   - done = 1 for that cycle, alongside out_valid.
//   - The next valid sample is treated as a start.
//  count saturates at 2^CNT_W-1 in free-running mode.
//  Bubbles (in_valid = 0) are allowed anywhere; S, count, and overflow hold.
//  acc_clear with in_valid = 0 is ignored.
//  acc_clear on the sample that would be frame-final: the sample starts a new frame
//  (count = 1, no done).
//  Back-to-back valid samples are accepted every cycle; no stall, no ready.
//  reset_p mid-frame: all state clears immediately; the in-flight stage-1 sample is dropped.
// STRUCTURE
//  Package mac_pkg: ACC_W >= 2*DATA_W check constant, clamp-limit functions,
//  and ext() helpers for signed and unsigned modes.
//  Sub-module mac_sat_add (ACC_W, SIGNED, SATURATE): combinational a+b -> sum, ovf.
//  Pipeline registers and the frame counter stay in mac_unit_pipe.
// TESTING
//  1 Defaults; reset_p high 10 ns -> P = S = count = 0, out_valid = done = overflow = 0.
//  2 Valid pairs (15,17), (40,45), (47,145), (255,255), first with acc_clear:
//    -> P = 255, 1800, 6815, 65025.
//    -> S = 255, 2055, 8870, 73895; done = 1 with S = 73895, count = 4.
//  3 ACC_W = 16, SATURATE = 1, FRAME_LEN = 0; (255,255) x2 with clear on first
//    -> S = 0xFFFF, overflow = 1.
//    With SATURATE = 0 -> S = 0xFC02, overflow = 1.
//  4 SIGNED = 1; (-128,127) then (-128,127) with clear on first
//    -> P = 0xC080, S = -16256 then -32512.
//  5 Bubbles: valid, 3 idle cycles, valid -> S, count hold during idle; fifth sample after
//    done restarts with count = 1, S = that product.
//  6 Assert reset_p mid-frame (count = 2, P pending)
//    -> S = 0, count = 0 at once; the dropped sample never reaches S.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared constants and helpers for the pipelined multiply-accumulate unit:
// accumulator width check, saturation limits and product extension.
package mac_pkg;

  // Widest accumulator the helpers below can describe.
  localparam int MAX_W = 64;

  // The accumulator must hold at least one full-width product.
  function automatic bit acc_w_ok(input int data_w, input int acc_w);
    return (acc_w >= 2 * data_w);
  endfunction

  // Largest representable value of a w-bit accumulator, right-aligned in MAX_W bits.
  function automatic logic [MAX_W-1:0] sat_max(input int w, input bit sgn);
    logic [MAX_W-1:0] ones;
    ones = '1;
    if (sgn) begin
      return ones >> (MAX_W - w + 1);
    end
    return ones >> (MAX_W - w);
  endfunction

  // Smallest representable value; the signed form is ~max, whose low w bits are 100..0.
  function automatic logic [MAX_W-1:0] sat_min(input int w, input bit sgn);
    if (sgn) begin
      return ~sat_max(w, 1'b1);
    end
    return '0;
  endfunction

  // Zero-extend the low w bits of v to MAX_W bits.
  function automatic logic [MAX_W-1:0] ext_u(input logic [MAX_W-1:0] v, input int w);
    logic [MAX_W-1:0] t;
    t = v << (MAX_W - w);
    return t >> (MAX_W - w);
  endfunction

  // Sign-extend the low w bits of v to MAX_W bits.
  function automatic logic [MAX_W-1:0] ext_s(input logic [MAX_W-1:0] v, input int w);
    logic [MAX_W-1:0] t;
    logic [MAX_W-1:0] r;
    t = v << (MAX_W - w);
    r = $signed(t) >>> (MAX_W - w);
    return r;
  endfunction

endpackage

// File: rtl/mac_unit_pipe_sat_add.sv
// Combinational accumulator adder: a + b evaluated one bit wider than the
// accumulator, with an out-of-range flag and optional clamping to the limits.
module mac_sat_add
  import mac_pkg::*;
#(
  parameter int ACC_W    = 20,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 1
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  localparam logic [ACC_W-1:0] LIM_MAX = ACC_W'(sat_max(ACC_W, SIGNED != 0));
  localparam logic [ACC_W-1:0] LIM_MIN = ACC_W'(sat_min(ACC_W, SIGNED != 0));

  logic [ACC_W:0] a_x;
  logic [ACC_W:0] b_x;
  logic [ACC_W:0] full;

  // Wide add, range detection, then clamp or wrap.
  always_comb begin
    if (SIGNED != 0) begin
      a_x = {a[ACC_W-1], a};
      b_x = {b[ACC_W-1], b};
    end else begin
      a_x = {1'b0, a};
      b_x = {1'b0, b};
    end
    full = a_x + b_x;

    // Signed: the two top bits disagree when the true sum left the range.
    // Unsigned: only a carry out can leave the range.
    if (SIGNED != 0) begin
      ovf = full[ACC_W] ^ full[ACC_W-1];
    end else begin
      ovf = full[ACC_W];
    end

    sum = full[ACC_W-1:0];
    if (ovf && (SATURATE != 0)) begin
      // A set top bit on signed overflow means the true sum went below the minimum.
      if ((SIGNED != 0) && full[ACC_W]) begin
        sum = LIM_MIN;
      end else begin
        sum = LIM_MAX;
      end
    end
  end

endmodule

// File: rtl/mac_unit_pipe.sv
// Two-stage pipelined multiply-accumulate with valid handshake, signed or
// unsigned operands, saturating or wrapping accumulator and frame counting
// with automatic restart after each completed frame.
module mac_unit_pipe
  import mac_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 20,
  parameter int SIGNED    = 0,
  parameter int SATURATE  = 1,
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic                  clock,
  input  logic                  reset_p,
  input  logic                  in_valid,
  input  logic                  acc_clear,
  input  logic [DATA_W-1:0]     A,
  input  logic [DATA_W-1:0]     B,
  output logic [2*DATA_W-1:0]   P,
  output logic [ACC_W-1:0]      S,
  output logic                  out_valid,
  output logic                  done,
  output logic                  overflow,
  output logic [CNT_W-1:0]      count
);

  localparam int              PW        = 2 * DATA_W;
  localparam bit              ACC_W_OK  = acc_w_ok(DATA_W, ACC_W);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_LEN);

  if (!ACC_W_OK) begin : g_acc_w_check
    $error("mac_unit_pipe: ACC_W must be at least 2*DATA_W");
  end

  logic [PW-1:0]    prod;
  logic             v1;
  logic             clr1;
  logic             frame_end;
  logic [ACC_W-1:0] p_ext;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic             start;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_next;
  logic             frame_hit;

  // Full-width product of the incoming operands.
  always_comb begin
    if (SIGNED != 0) begin
      prod = $signed({{DATA_W{A[DATA_W-1]}}, A}) * $signed({{DATA_W{B[DATA_W-1]}}, B});
    end else begin
      prod = {{DATA_W{1'b0}}, A} * {{DATA_W{1'b0}}, B};
    end
  end

  // Stage 1: register the product and tag it; P holds through bubbles.
  always_ff @(posedge clock or posedge reset_p) begin
    if (reset_p) begin
      P    <= '0;
      v1   <= 1'b0;
      clr1 <= 1'b0;
    end else begin
      v1   <= in_valid;
      clr1 <= in_valid & acc_clear;
      if (in_valid) begin
        P <= prod;
      end
    end
  end

  // Product widened to the accumulator, sign- or zero-extended.
  always_comb begin
    if (SIGNED != 0) begin
      p_ext = ACC_W'(ext_s(MAX_W'(P), PW));
    end else begin
      p_ext = ACC_W'(ext_u(MAX_W'(P), PW));
    end
  end

  mac_sat_add #(
    .ACC_W   (ACC_W),
    .SIGNED  (SIGNED),
    .SATURATE(SATURATE)
  ) u_add (
    .a  (S),
    .b  (p_ext),
    .sum(add_sum),
    .ovf(add_ovf)
  );

  // Start/continue decision and the next sample count.
  always_comb begin
    // frame_end survives bubbles, so the first valid sample after a frame restarts.
    start = clr1 | frame_end;
    if (count == CNT_MAX) begin
      cnt_inc = count;
    end else begin
      cnt_inc = count + CNT_W'(1);
    end
    cnt_next  = start ? CNT_W'(1) : cnt_inc;
    frame_hit = (FRAME_LEN > 0) && (cnt_next == FRAME_CNT);
  end

  // Stage 2: accumulate, track overflow and frame progress.
  always_ff @(posedge clock or posedge reset_p) begin
    if (reset_p) begin
      S         <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      out_valid <= v1;
      done      <= v1 & frame_hit;
      if (v1) begin
        // A lone product always fits because ACC_W >= 2*DATA_W, so a start never overflows.
        S         <= start ? p_ext : add_sum;
        overflow  <= start ? 1'b0 : (overflow | add_ovf);
        count     <= cnt_next;
        frame_end <= frame_hit;
      end
    end
  end

endmodule

// File: tb/tb_mac_unit_pipe.sv
// Bench for mac_unit_pipe: four configurations share one stimulus stream and
// are compared every cycle against an integer-arithmetic model, plus
// hand-computed expectations for the documented scenarios.
module tb_mac_unit_pipe;

  typedef logic signed [63:0] val_t;

  localparam int NK      = 4;
  localparam int CNT_MAX = 255;
  // instance:            base  sat16 wrap16 signed
  localparam int C_ACC [NK] = '{20, 16, 16, 20};
  localparam int C_SGN [NK] = '{0,  0,  0,  1};
  localparam int C_SAT [NK] = '{1,  1,  0,  1};
  localparam int C_FRM [NK] = '{4,  0,  0,  3};

  typedef struct packed {
    logic signed [63:0] p;
    logic signed [63:0] s;
    logic signed [63:0] pend_p;
    int                 cnt;
    bit                 ov;
    bit                 ovld;
    bit                 done;
    bit                 fend;
    bit                 pend_v;
    bit                 pend_c;
  } mstate_t;

  logic       clock     = 1'b0;
  logic       reset_p   = 1'b1;
  logic       in_valid  = 1'b0;
  logic       acc_clear = 1'b0;
  logic [7:0] a_in      = '0;
  logic [7:0] b_in      = '0;

  logic [15:0] p_o    [NK];
  logic        ovld_o [NK];
  logic        dn_o   [NK];
  logic        ov_o   [NK];
  logic [7:0]  cnt_o  [NK];
  logic [19:0] s0;
  logic [15:0] s1;
  logic [15:0] s2;
  logic [19:0] s3;

  val_t act_p [NK];
  val_t act_s [NK];

  mstate_t m [NK];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  mac_unit_pipe #(.DATA_W(8), .ACC_W(20), .SIGNED(0), .SATURATE(1), .FRAME_LEN(4), .CNT_W(8)) dut0 (
    .clock(clock), .reset_p(reset_p), .in_valid(in_valid), .acc_clear(acc_clear), .A(a_in), .B(b_in),
    .P(p_o[0]), .S(s0), .out_valid(ovld_o[0]), .done(dn_o[0]), .overflow(ov_o[0]), .count(cnt_o[0]));
  mac_unit_pipe #(.DATA_W(8), .ACC_W(16), .SIGNED(0), .SATURATE(1), .FRAME_LEN(0), .CNT_W(8)) dut1 (
    .clock(clock), .reset_p(reset_p), .in_valid(in_valid), .acc_clear(acc_clear), .A(a_in), .B(b_in),
    .P(p_o[1]), .S(s1), .out_valid(ovld_o[1]), .done(dn_o[1]), .overflow(ov_o[1]), .count(cnt_o[1]));
  mac_unit_pipe #(.DATA_W(8), .ACC_W(16), .SIGNED(0), .SATURATE(0), .FRAME_LEN(0), .CNT_W(8)) dut2 (
    .clock(clock), .reset_p(reset_p), .in_valid(in_valid), .acc_clear(acc_clear), .A(a_in), .B(b_in),
    .P(p_o[2]), .S(s2), .out_valid(ovld_o[2]), .done(dn_o[2]), .overflow(ov_o[2]), .count(cnt_o[2]));
  mac_unit_pipe #(.DATA_W(8), .ACC_W(20), .SIGNED(1), .SATURATE(1), .FRAME_LEN(3), .CNT_W(8)) dut3 (
    .clock(clock), .reset_p(reset_p), .in_valid(in_valid), .acc_clear(acc_clear), .A(a_in), .B(b_in),
    .P(p_o[3]), .S(s3), .out_valid(ovld_o[3]), .done(dn_o[3]), .overflow(ov_o[3]), .count(cnt_o[3]));

  always_comb begin
    for (int k = 0; k < NK; k++) begin
      act_p[k] = (C_SGN[k] != 0) ? val_t'($signed(p_o[k])) : val_t'(p_o[k]);
    end
    act_s[0] = val_t'(s0);
    act_s[1] = val_t'(s1);
    act_s[2] = val_t'(s2);
    act_s[3] = val_t'($signed(s3));
  end

  function automatic longint lim_lo(int k);
    if (C_SGN[k] != 0) return -(longint'(1) << (C_ACC[k] - 1));
    return 0;
  endfunction

  function automatic longint lim_hi(int k);
    if (C_SGN[k] != 0) return (longint'(1) << (C_ACC[k] - 1)) - 1;
    return (longint'(1) << C_ACC[k]) - 1;
  endfunction

  function automatic longint opnd(int k, logic [7:0] x);
    if (C_SGN[k] != 0) return longint'($signed(x));
    return longint'(x);
  endfunction

  function automatic longint wrap(longint x, longint lo, int w);
    longint md;
    longint r;
    md = longint'(1) << w;
    r  = (x - lo) % md;
    if (r < 0) r = r + md;
    return r + lo;
  endfunction

  // Model: the product appears one edge after the sample, the accumulator one edge later.
  function automatic mstate_t model_next(int k, mstate_t c, logic v, logic clr, logic [7:0] a, logic [7:0] b);
    mstate_t n = c;
    longint  sum;
    longint  lo;
    longint  hi;
    bit      st;
    bit      oor;
    lo     = lim_lo(k);
    hi     = lim_hi(k);
    n.ovld = c.pend_v;
    n.done = 1'b0;
    if (c.pend_v) begin
      st  = c.pend_c || c.fend;
      sum = st ? c.pend_p : c.s + c.pend_p;
      oor = (sum < lo) || (sum > hi);
      if (oor) sum = (C_SAT[k] != 0) ? ((sum < lo) ? lo : hi) : wrap(sum, lo, C_ACC[k]);
      n.s    = sum;
      n.ov   = st ? oor : (c.ov || oor);
      n.cnt  = st ? 1 : ((c.cnt < CNT_MAX) ? c.cnt + 1 : c.cnt);
      n.done = (C_FRM[k] > 0) && (n.cnt == C_FRM[k]);
      n.fend = n.done;
    end
    if (v) begin
      n.p      = opnd(k, a) * opnd(k, b);
      n.pend_p = n.p;
    end
    n.pend_v = v;
    n.pend_c = v && clr;
    return n;
  endfunction

  always @(posedge clock or posedge reset_p) begin
    if (reset_p) begin
      for (int k = 0; k < NK; k++) m[k] <= '0;
    end else begin
      for (int k = 0; k < NK; k++) m[k] <= model_next(k, m[k], in_valid, acc_clear, a_in, b_in);
    end
  end

  task automatic chk(input string name, input val_t act, input val_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every instance against the model.
  initial begin
    forever begin
      @(negedge clock);
      for (int k = 0; k < NK; k++) begin
        chk($sformatf("P[%0d]", k), act_p[k], m[k].p);
        chk($sformatf("S[%0d]", k), act_s[k], m[k].s);
        chk($sformatf("count[%0d]", k), val_t'(cnt_o[k]), val_t'(m[k].cnt));
        chk($sformatf("out_valid[%0d]", k), val_t'(ovld_o[k]), val_t'(m[k].ovld));
        chk($sformatf("done[%0d]", k), val_t'(dn_o[k]), val_t'(m[k].done));
        chk($sformatf("overflow[%0d]", k), val_t'(ov_o[k]), val_t'(m[k].ov));
      end
    end
  end

  task automatic cyc(input logic v, input logic c, input logic [7:0] a, input logic [7:0] b);
    in_valid  = v;
    acc_clear = c;
    a_in      = a;
    b_in      = b;
    @(negedge clock);
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_P", act_p[0], 0);
    chk("rst_S", act_s[0], 0);
    chk("rst_count", val_t'(cnt_o[0]), 0);
    chk("rst_out_valid", val_t'(ovld_o[0]), 0);
    chk("rst_done", val_t'(dn_o[0]), 0);
    chk("rst_overflow", val_t'(ov_o[0]), 0);
    reset_p = 1'b0;
    @(negedge clock);

    // four-sample frame
    cyc(1, 1, 15, 17);   chk("f_P1", act_p[0], 255);
    cyc(1, 0, 40, 45);   chk("f_P2", act_p[0], 1800);  chk("f_S1", act_s[0], 255);
    cyc(1, 0, 47, 145);  chk("f_P3", act_p[0], 6815);  chk("f_S2", act_s[0], 2055);
    cyc(1, 0, 255, 255); chk("f_P4", act_p[0], 65025); chk("f_S3", act_s[0], 8870);
    cyc(0, 0, 0, 0);
    chk("f_S4", act_s[0], 73895);
    chk("f_done", val_t'(dn_o[0]), 1);
    chk("f_count", val_t'(cnt_o[0]), 4);
    cyc(0, 0, 0, 0);     chk("f_done_pulse", val_t'(dn_o[0]), 0);

    // 16-bit accumulator: saturate vs wrap
    cyc(1, 1, 255, 255);
    cyc(1, 0, 255, 255); chk("sat_ov_cleared", val_t'(ov_o[1]), 0);
    cyc(0, 0, 0, 0);
    chk("sat_S", act_s[1], 65535);
    chk("sat_ov", val_t'(ov_o[1]), 1);
    chk("wrap_S", act_s[2], 64514);
    chk("wrap_ov", val_t'(ov_o[2]), 1);

    // signed operands
    cyc(1, 1, 8'h80, 8'h7f); chk("sgn_P_raw", val_t'(p_o[3]), 49280);
    cyc(1, 0, 8'h80, 8'h7f); chk("sgn_S1", act_s[3], -16256);
    cyc(0, 0, 0, 0);         chk("sgn_S2", act_s[3], -32512);

    // bubbles, ignored clear, restart after done, clear on the frame-final sample
    cyc(1, 1, 2, 3);
    cyc(0, 1, 0, 0); chk("bub_S1", act_s[0], 6); chk("bub_cnt1", val_t'(cnt_o[0]), 1);
    cyc(0, 1, 0, 0); chk("bub_hold_S", act_s[0], 6); chk("bub_hold_ovld", val_t'(ovld_o[0]), 0);
    cyc(0, 0, 0, 0); chk("bub_hold_cnt", val_t'(cnt_o[0]), 1);
    cyc(1, 0, 4, 5);
    cyc(1, 0, 1, 1); chk("bub_S2", act_s[0], 26); chk("bub_cnt2", val_t'(cnt_o[0]), 2);
    cyc(1, 0, 6, 7); chk("bub_S3", act_s[0], 27);
    cyc(0, 0, 0, 0); chk("bub_S4", act_s[0], 69); chk("bub_done", val_t'(dn_o[0]), 1);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 9, 9);
    cyc(0, 0, 0, 0);
    chk("rst_after_done_S", act_s[0], 81);
    chk("rst_after_done_cnt", val_t'(cnt_o[0]), 1);
    chk("rst_after_done_dn", val_t'(dn_o[0]), 0);
    cyc(1, 0, 1, 1);
    cyc(1, 0, 1, 1);
    cyc(1, 1, 5, 5); chk("fin_clr_pre_cnt", val_t'(cnt_o[0]), 3);
    cyc(0, 0, 0, 0);
    chk("fin_clr_S", act_s[0], 25);
    chk("fin_clr_cnt", val_t'(cnt_o[0]), 1);
    chk("fin_clr_done", val_t'(dn_o[0]), 0);

    // reset mid-frame with a product in flight
    cyc(1, 1, 3, 3);
    cyc(1, 0, 2, 2);
    cyc(1, 0, 7, 7);
    chk("mid_S", act_s[0], 13);
    chk("mid_cnt", val_t'(cnt_o[0]), 2);
    in_valid = 1'b0;
    #2 reset_p = 1'b1;
    #1;
    chk("mid_rst_S", act_s[0], 0);
    chk("mid_rst_cnt", val_t'(cnt_o[0]), 0);
    chk("mid_rst_P", act_p[0], 0);
    #1 reset_p = 1'b0;
    @(negedge clock);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("drop_S", act_s[0], 0);
    chk("drop_ovld", val_t'(ovld_o[0]), 0);

    // free-running count saturates
    cyc(1, 1, 1, 1);
    for (int i = 0; i < 299; i++) cyc(1, 0, 1, 1);
    cyc(0, 0, 0, 0);
    chk("cnt_sat", val_t'(cnt_o[1]), 255);
    chk("cnt_sat_S", act_s[1], 300);
    cyc(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
